// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl
// Data-side cache between the RISC-V core and main memory.
// Direct-mapped, write-through, no-write-allocate. Loads that hit return data
// in the same cycle. A load miss stalls the core while the whole line is
// refilled over the ready-handshake bus. Every store stalls the core until
// memory accepts the write, then releases it for exactly one cycle.
module data_cache_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int LINES      = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        re,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [31:0]       Wdata,
    output logic [31:0]       Rdata,
    output logic              Stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    // Address split: | tag | index | word offset | byte offset |
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int IDX_LSB = OFF_W + 2;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    // Access sizes on re / we
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Cache storage
    logic [31:0]      data_mem [LINES][LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid;

    // Refill word counter
    logic [OFF_W-1:0] cnt;

    // Decoded address fields; the core holds Data_addr steady while stalled
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag_in;
    logic [OFF_W-1:0] word_off;
    logic [1:0]       byte_off;

    logic        hit;
    logic [31:0] line_word;
    logic [31:0] rd_data;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] merge_word;

    // Strobes from the FSM into the storage update logic
    logic refill_start;
    logic refill_beat;
    logic refill_last;
    logic write_merge;

    assign idx       = Data_addr[TAG_LSB-1:IDX_LSB];
    assign tag_in    = Data_addr[ADDR_W-1:TAG_LSB];
    assign word_off  = Data_addr[IDX_LSB-1:2];
    assign byte_off  = Data_addr[1:0];
    assign hit       = valid[idx] && (tag_mem[idx] == tag_in);
    assign line_word = data_mem[idx][word_off];

    // Load lane extraction: shift the addressed bytes down and zero-extend
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_data = 32'h0;
        case (re)
            SZ_BYTE: rd_data = (line_word >> {byte_off, 3'b000}) & 32'h0000_00FF;
            SZ_HALF: rd_data = (line_word >> {byte_off[1], 4'b0000}) & 32'h0000_FFFF;
            SZ_WORD: rd_data = line_word;
            default: rd_data = 32'h0;
        endcase
    end

    // Store lane placement: byte enables and data shifted to the target lanes
    always_comb begin
        wr_be   = 4'h0;
        wr_data = 32'h0;
        case (we)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << byte_off;
                wr_data = Wdata << {byte_off, 3'b000};
            end
            SZ_HALF: begin
                wr_be   = 4'b0011 << {byte_off[1], 1'b0};
                wr_data = Wdata << {byte_off[1], 4'b0000};
            end
            SZ_WORD: begin
                wr_be   = 4'hF;
                wr_data = Wdata;
            end
            default: begin
                wr_be   = 4'h0;
                wr_data = 32'h0;
            end
        endcase
    end

    // Merge the written bytes into the cached copy of the word for a store hit
    always_comb begin
        merge_word = line_word;
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                merge_word[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // State register
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, bus requests and core handshake; all forced quiet while in reset
    always_comb begin
        state_next   = state;
        Stall        = 1'b0;
        Rdata        = 32'h0;
        mem_addr     = '0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_be       = 4'h0;
        mem_wdata    = 32'h0;
        refill_start = 1'b0;
        refill_beat  = 1'b0;
        refill_last  = 1'b0;
        write_merge  = 1'b0;

        if (re != 2'd0 && hit) begin
            Rdata = rd_data;
        end

        case (state)
            IDLE: begin
                if (we != 2'd0) begin
                    Stall      = 1'b1;
                    state_next = WRITE;
                end else if (re != 2'd0 && !hit) begin
                    Stall        = 1'b1;
                    refill_start = 1'b1;
                    state_next   = REFILL;
                end
            end
            REFILL: begin
                Stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {Data_addr[ADDR_W-1:IDX_LSB], cnt, 2'b00};
                if (mem_ready) begin
                    refill_beat = 1'b1;
                    if (cnt == LAST_WORD) begin
                        refill_last = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            WRITE: begin
                Stall     = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {Data_addr[ADDR_W-1:2], 2'b00};
                mem_be    = wr_be;
                mem_wdata = wr_data;
                if (mem_ready) begin
                    write_merge = hit;
                    state_next  = DONE;
                end
            end
            DONE: begin
                // One free cycle for the core to commit the store
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!reset) begin
            Stall        = 1'b0;
            Rdata        = 32'h0;
            mem_rd       = 1'b0;
            mem_wr       = 1'b0;
            mem_be       = 4'h0;
            mem_wdata    = 32'h0;
            mem_addr     = '0;
            refill_start = 1'b0;
            refill_beat  = 1'b0;
            refill_last  = 1'b0;
            write_merge  = 1'b0;
        end
    end

    // Valid bits and refill counter; a line is invalid from refill start until its last word lands
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= '0;
            cnt   <= '0;
        end else begin
            if (refill_start) begin
                valid[idx] <= 1'b0;
                cnt        <= '0;
            end
            if (refill_beat) begin
                cnt <= cnt + 1'b1;
                if (refill_last) begin
                    valid[idx] <= 1'b1;
                end
            end
        end
    end

    // Line data and tags: refill words and store-hit merges
    // NOTE: the data/tag arrays are not reset; the cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (refill_beat) begin
            data_mem[idx][cnt] <= mem_rdata;
        end else if (write_merge) begin
            data_mem[idx][word_off] <= merge_word;
        end
        if (refill_last) begin
            tag_mem[idx] <= tag_in;
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb_data_cache_ctrl
// Directed bench for data_cache_ctrl: a small word-addressed memory model
// answers the bus with a programmable ready delay; each task drives one
// scenario and compares against hand-computed values.
module tb_data_cache_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  re;
    logic [1:0]  we;
    logic [11:0] Data_addr;
    logic [31:0] Wdata;
    logic [31:0] Rdata;
    logic        Stall;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks;
    int passes;

    logic [31:0] mem_model [1024];
    int          ready_delay;
    int          wait_cnt;
    bit          overlap_seen;

    data_cache_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .re        (re),
        .we        (we),
        .Data_addr (Data_addr),
        .Wdata     (Wdata),
        .Rdata     (Rdata),
        .Stall     (Stall),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: decides ready on the falling edge, DUT samples it on the rising edge
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            if (reset && (mem_rd || mem_wr)) begin
                if (wait_cnt >= ready_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_model[mem_addr[11:2]];
                    if (mem_wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mem_be[b]) mem_model[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                    end
                    wait_cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hDEAD_DEAD;
                    wait_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // Record any cycle where both bus requests are raised
    initial begin
        overlap_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1 && mem_wr === 1'b1) overlap_seen = 1'b1;
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: run still active at 200000, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [11:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        re        = r;
        we        = w;
        Data_addr = a;
        Wdata     = d;
    endtask

    // Waits through a refill until Stall drops; reports mem_rd cycles and first address
    task automatic run_refill(output int rd_cycles, output logic [11:0] first_addr, output bit ok);
        bit finished;
        rd_cycles  = 0;
        first_addr = 12'hFFF;
        finished   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!finished) begin
                @(negedge clk);
                if (Stall === 1'b0) begin
                    finished = 1'b1;
                end else if (mem_rd === 1'b1) begin
                    if (rd_cycles == 0) first_addr = mem_addr;
                    rd_cycles++;
                end
            end
        end
        ok = finished;
    endtask

    task automatic test_reset();
        reset = 1'b0; re = 2'd3; we = 2'd0; Data_addr = 12'h040; Wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (Stall !== 1'b0) $display("FAIL rst_stall: got %b expected 0", Stall); else passes++;
        checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) $display("FAIL rst_req: rd=%b wr=%b expected 0 0", mem_rd, mem_wr); else passes++;
        checks++; if (Rdata !== 32'h0) $display("FAIL rst_rdata: got %h expected 00000000", Rdata); else passes++;
        @(posedge clk);
        #1;
        reset = 1'b1; re = 2'd0;
        @(negedge clk);
        checks++; if (Stall !== 1'b0) $display("FAIL idle_stall: got %b expected 0", Stall); else passes++;
    endtask

    task automatic test_refill_miss();
        logic [11:0] exp_addr;
        drive(2'd3, 2'd0, 12'h040, 32'h0);
        @(negedge clk);
        checks++; if (Stall !== 1'b1 || mem_rd !== 1'b0) $display("FAIL miss_detect: stall=%b rd=%b expected 1 0", Stall, mem_rd); else passes++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_addr = 12'h040 + 12'(4 * i);
            checks++;
            if (Stall !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== exp_addr)
                $display("FAIL refill_beat%0d: stall=%b rd=%b addr=%h expected 1 1 %h", i, Stall, mem_rd, mem_addr, exp_addr);
            else passes++;
        end
        @(negedge clk);
        checks++; if (Stall !== 1'b0 || Rdata !== 32'h0000_0011) $display("FAIL refill_hit: stall=%b rdata=%h expected 0 00000011", Stall, Rdata); else passes++;
    endtask

    task automatic test_byte_load();
        drive(2'd1, 2'd0, 12'h049, 32'h0);
        @(negedge clk);
        checks++; if (Stall !== 1'b0 || Rdata !== 32'h0000_00CC) $display("FAIL byte_load: stall=%b rdata=%h expected 0 000000cc", Stall, Rdata); else passes++;
        drive(2'd1, 2'd0, 12'h04B, 32'h0);
        @(negedge clk);
        checks++; if (Rdata !== 32'h0000_00AA) $display("FAIL byte_load_top: rdata=%h expected 000000aa", Rdata); else passes++;
        drive(2'd2, 2'd0, 12'h04B, 32'h0);
        @(negedge clk);
        checks++; if (Rdata !== 32'h0000_AABB) $display("FAIL half_align: rdata=%h expected 0000aabb", Rdata); else passes++;
        drive(2'd3, 2'd0, 12'h04B, 32'h0);
        @(negedge clk);
        checks++; if (Stall !== 1'b0 || Rdata !== 32'hAABB_CC33) $display("FAIL word_align: stall=%b rdata=%h expected 0 aabbcc33", Stall, Rdata); else passes++;
    endtask

    task automatic test_store_hit();
        drive(2'd0, 2'd2, 12'h046, 32'h0000_BEEF);
        @(negedge clk);
        checks++; if (Stall !== 1'b1 || mem_wr !== 1'b0) $display("FAIL store_detect: stall=%b wr=%b expected 1 0", Stall, mem_wr); else passes++;
        @(negedge clk);
        checks++; if (Stall !== 1'b1 || mem_wr !== 1'b1 || mem_rd !== 1'b0) $display("FAIL store_req: stall=%b wr=%b rd=%b expected 1 1 0", Stall, mem_wr, mem_rd); else passes++;
        checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_0000 || mem_addr !== 12'h044)
            $display("FAIL store_lanes: be=%b wdata=%h addr=%h expected 1100 beef0000 044", mem_be, mem_wdata, mem_addr); else passes++;
        @(negedge clk);
        checks++; if (Stall !== 1'b0 || mem_wr !== 1'b0) $display("FAIL store_done: stall=%b wr=%b expected 0 0", Stall, mem_wr); else passes++;
        drive(2'd3, 2'd0, 12'h044, 32'h0);
        @(negedge clk);
        checks++; if (Stall !== 1'b0 || mem_rd !== 1'b0 || Rdata !== 32'hBEEF_0022)
            $display("FAIL store_merge: stall=%b rd=%b rdata=%h expected 0 0 beef0022", Stall, mem_rd, Rdata); else passes++;
        drive(2'd2, 2'd0, 12'h046, 32'h0);
        @(negedge clk);
        checks++; if (Rdata !== 32'h0000_BEEF) $display("FAIL store_half_read: rdata=%h expected 0000beef", Rdata); else passes++;
    endtask

    task automatic test_store_miss();
        int          wr_cycles;
        int          rd_cycles;
        bit          stable;
        bit          finished;
        bit          ok;
        logic [11:0] first_addr;
        ready_delay = 3;
        drive(2'd0, 2'd3, 12'h800, 32'h1234_5678);
        @(negedge clk);
        checks++; if (Stall !== 1'b1) $display("FAIL wmiss_detect: stall=%b expected 1", Stall); else passes++;
        wr_cycles = 0; stable = 1'b1; finished = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!finished) begin
                @(negedge clk);
                if (Stall === 1'b0) begin
                    finished = 1'b1;
                end else if (mem_wr === 1'b1) begin
                    wr_cycles++;
                    if (mem_addr !== 12'h800 || mem_be !== 4'hF || mem_wdata !== 32'h1234_5678) stable = 1'b0;
                end
            end
        end
        ready_delay = 0;
        checks++; if (finished !== 1'b1) $display("FAIL wmiss_timeout: done=%b expected 1", finished); else passes++;
        checks++; if (wr_cycles != 4) $display("FAIL wmiss_hold: wr cycles=%0d expected 4", wr_cycles); else passes++;
        checks++; if (stable !== 1'b1) $display("FAIL wmiss_stable: stable=%b expected 1", stable); else passes++;
        drive(2'd3, 2'd0, 12'h800, 32'h0);
        @(negedge clk);
        checks++; if (Stall !== 1'b1) $display("FAIL no_alloc: stall=%b expected 1", Stall); else passes++;
        run_refill(rd_cycles, first_addr, ok);
        checks++; if (ok !== 1'b1 || rd_cycles != 4 || first_addr !== 12'h800)
            $display("FAIL wmiss_refill: ok=%b beats=%0d first=%h expected 1 4 800", ok, rd_cycles, first_addr); else passes++;
        checks++; if (Rdata !== 32'h1234_5678) $display("FAIL wmiss_data: rdata=%h expected 12345678", Rdata); else passes++;
    endtask

    task automatic test_evict();
        int          rd_cycles;
        bit          ok;
        logic [11:0] first_addr;
        drive(2'd3, 2'd0, 12'h240, 32'h0);
        @(negedge clk);
        checks++; if (Stall !== 1'b1) $display("FAIL evict_miss: stall=%b expected 1", Stall); else passes++;
        run_refill(rd_cycles, first_addr, ok);
        checks++; if (ok !== 1'b1 || rd_cycles != 4 || first_addr !== 12'h240 || Rdata !== 32'h5550_0000)
            $display("FAIL evict_refill: ok=%b beats=%0d first=%h rdata=%h expected 1 4 240 55500000", ok, rd_cycles, first_addr, Rdata); else passes++;
        drive(2'd3, 2'd0, 12'h040, 32'h0);
        @(negedge clk);
        checks++; if (Stall !== 1'b1) $display("FAIL evicted_miss: stall=%b expected 1", Stall); else passes++;
        run_refill(rd_cycles, first_addr, ok);
        checks++; if (ok !== 1'b1 || rd_cycles != 4 || Rdata !== 32'h0000_0011)
            $display("FAIL evicted_refill: ok=%b beats=%0d rdata=%h expected 1 4 00000011", ok, rd_cycles, Rdata); else passes++;
    endtask

    task automatic test_reset_mid_refill();
        int          rd_cycles;
        bit          ok;
        logic [11:0] first_addr;
        drive(2'd3, 2'd0, 12'h100, 32'h0);
        @(negedge clk);
        checks++; if (Stall !== 1'b1) $display("FAIL mid_miss: stall=%b expected 1", Stall); else passes++;
        @(negedge clk);
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h100) $display("FAIL mid_beat0: rd=%b addr=%h expected 1 100", mem_rd, mem_addr); else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (Stall !== 1'b0 || mem_rd !== 1'b0 || Rdata !== 32'h0)
            $display("FAIL mid_rst_out: stall=%b rd=%b rdata=%h expected 0 0 00000000", Stall, mem_rd, Rdata); else passes++;
        @(negedge clk);
        checks++; if (Stall !== 1'b0 || mem_rd !== 1'b0) $display("FAIL mid_rst_hold: stall=%b rd=%b expected 0 0", Stall, mem_rd); else passes++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (Stall !== 1'b1 || mem_rd !== 1'b0) $display("FAIL mid_rerequest: stall=%b rd=%b expected 1 0", Stall, mem_rd); else passes++;
        run_refill(rd_cycles, first_addr, ok);
        checks++; if (ok !== 1'b1 || rd_cycles != 4 || first_addr !== 12'h100 || Rdata !== 32'hC0DE_0000)
            $display("FAIL mid_full_refill: ok=%b beats=%0d first=%h rdata=%h expected 1 4 100 c0de0000", ok, rd_cycles, first_addr, Rdata); else passes++;
        drive(2'd3, 2'd0, 12'h240, 32'h0);
        @(negedge clk);
        checks++; if (Stall !== 1'b1) $display("FAIL rst_cleared_valid: stall=%b expected 1", Stall); else passes++;
        run_refill(rd_cycles, first_addr, ok);
        checks++; if (ok !== 1'b1 || Rdata !== 32'h5550_0000) $display("FAIL rst_refill_240: ok=%b rdata=%h expected 1 55500000", ok, Rdata); else passes++;
        drive(2'd0, 2'd0, 12'h000, 32'h0);
        @(negedge clk);
        checks++; if (Stall !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) $display("FAIL final_idle: stall=%b rd=%b wr=%b expected 0 0 0", Stall, mem_rd, mem_wr); else passes++;
    endtask

    task automatic test_protocol();
        checks++; if (overlap_seen !== 1'b0) $display("FAIL rd_wr_overlap: seen=%b expected 0", overlap_seen); else passes++;
    endtask

    initial begin
        checks      = 0;
        passes      = 0;
        ready_delay = 0;
        reset       = 1'b0;
        re          = 2'd0;
        we          = 2'd0;
        Data_addr   = 12'h0;
        Wdata       = 32'h0;
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
        mem_model[12'h040 >> 2] = 32'h0000_0011;
        mem_model[12'h044 >> 2] = 32'h0000_0022;
        mem_model[12'h048 >> 2] = 32'hAABB_CC33;
        mem_model[12'h04C >> 2] = 32'h0000_0044;
        for (int i = 0; i < 4; i++) begin
            mem_model[(12'h240 >> 2) + i] = 32'h5550_0000 + 32'(i);
            mem_model[(12'h100 >> 2) + i] = 32'hC0DE_0000 + 32'(i);
        end

        test_reset();
        test_refill_miss();
        test_byte_load();
        test_store_hit();
        test_store_miss();
        test_evict();
        test_reset_mid_refill();
        test_protocol();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
